// File: rtl/fetch_unit_if.sv
// ============================================================================
// Module      : fetch_unit_if
// Description : Control and memory-side signal bundle for the instruction-fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface fetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              input_fetch_start;
    logic              input_fetch_abort;
    logic [ADDR_W-1:0] input_fetch_PC;
    logic              input_fetch_memReady;
    logic [DATA_W-1:0] input_fetch_memData;
    logic              output_fetch_memReq;
    logic [ADDR_W-1:0] output_fetch_memAddr;
    logic [DATA_W-1:0] output_fetch_IR;
    logic              output_fetch_PCWrite;
    logic [ADDR_W-1:0] output_fetch_newPC;
    logic              output_fetch_done;
    logic              output_fetch_error;
    logic              output_fetch_busy;

    // The fetch unit itself is the master of this bundle.
    modport master (
        input  input_fetch_start,
        input  input_fetch_abort,
        input  input_fetch_PC,
        input  input_fetch_memReady,
        input  input_fetch_memData,
        output output_fetch_memReq,
        output output_fetch_memAddr,
        output output_fetch_IR,
        output output_fetch_PCWrite,
        output output_fetch_newPC,
        output output_fetch_done,
        output output_fetch_error,
        output output_fetch_busy
    );

    modport slave (
        output input_fetch_start,
        output input_fetch_abort,
        output input_fetch_PC,
        output input_fetch_memReady,
        output input_fetch_memData,
        input  output_fetch_memReq,
        input  output_fetch_memAddr,
        input  output_fetch_IR,
        input  output_fetch_PCWrite,
        input  output_fetch_newPC,
        input  output_fetch_done,
        input  output_fetch_error,
        input  output_fetch_busy
    );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch sequencer: reads memory at the PC, loads IR,
//               advances the PC; seeds the PC on reset, handles abort/timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fetch_unit #(
    parameter int              ADDR_W   = 16,
    parameter int              DATA_W   = 16,
    parameter int              PC_STEP  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 16
) (
    input  logic        CLK,
    input  logic        Reset_n,
    fetch_unit_if.master bus
);

    localparam int                CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  c_CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic              c_TO_EN    = (TIMEOUT != 0);
    localparam logic [ADDR_W-1:0] c_STEP     = ADDR_W'(PC_STEP);

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IDLE = 3'd1,
        S_REQ  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] w_ir_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            r_state <= S_INIT;
            r_ir    <= '0;
            r_addr  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ir    <= w_ir_next;
            r_addr  <= w_addr_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ir_next    = r_ir;
        w_addr_next  = r_addr;
        w_cnt_next   = r_cnt;

        bus.output_fetch_memReq  = 1'b0;
        bus.output_fetch_memAddr = '0;
        bus.output_fetch_PCWrite = 1'b0;
        bus.output_fetch_newPC   = '0;
        bus.output_fetch_done    = 1'b0;
        bus.output_fetch_error   = 1'b0;
        bus.output_fetch_busy    = 1'b1;

        case (r_state)
            // INIT is also the reset state, so the PC is seeded while reset is held.
            S_INIT: begin
                bus.output_fetch_PCWrite = 1'b1;
                bus.output_fetch_newPC   = RESET_PC;
                w_state_next             = S_IDLE;
            end
            S_IDLE: begin
                bus.output_fetch_busy = 1'b0;
                if (bus.input_fetch_start) begin
                    w_state_next = S_REQ;
                    w_addr_next  = bus.input_fetch_PC;
                    w_cnt_next   = '0;
                end
            end
            S_REQ: begin
                bus.output_fetch_memReq  = 1'b1;
                bus.output_fetch_memAddr = r_addr;
                if (bus.input_fetch_abort) begin
                    w_state_next = S_IDLE;
                end else if (bus.input_fetch_memReady) begin
                    w_state_next = S_DONE;
                    w_ir_next    = bus.input_fetch_memData;
                end else if (c_TO_EN && (r_cnt == c_CNT_LAST)) begin
                    w_state_next = S_ERR;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                bus.output_fetch_PCWrite = 1'b1;
                bus.output_fetch_newPC   = r_addr + c_STEP;
                bus.output_fetch_done    = 1'b1;
                w_state_next             = S_IDLE;
            end
            S_ERR: begin
                bus.output_fetch_error = 1'b1;
                w_state_next           = S_IDLE;
            end
            default: begin
                w_state_next = S_INIT;
            end
        endcase
    end

    assign bus.output_fetch_IR = r_ir;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit: vector table plus scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fetch_unit;

    localparam int          ADDR_W   = 16;
    localparam int          DATA_W   = 16;
    localparam int          PC_STEP  = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam int          TIMEOUT  = 16;

    logic CLK     = 1'b0;
    logic Reset_n = 1'b0;
    always #5 CLK = ~CLK;

    fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fetch_unit #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .PC_STEP (PC_STEP),
        .RESET_PC(RESET_PC),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .CLK    (CLK),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bench-side program counter register, written through the DUT's PC port.
    logic [15:0] pc_reg;
    logic        pc_load     = 1'b0;
    logic [15:0] pc_load_val = '0;
    always @(posedge CLK) begin
        if (pc_load)                       pc_reg <= pc_load_val;
        else if (bus.output_fetch_PCWrite) pc_reg <= bus.output_fetch_newPC;
    end
    assign bus.input_fetch_PC = pc_reg;

    typedef enum logic [1:0] {K_DONE, K_ABORT, K_TMO} kind_t;
    typedef struct {
        kind_t       kind;
        logic [15:0] ir;
        logic [15:0] newpc;
    } exp_t;
    exp_t sb_q[$];
    int   pcw_count = 0;

    always @(negedge CLK) begin
        exp_t e;
        if (Reset_n) begin
            if (bus.output_fetch_PCWrite) pcw_count++;
            if (bus.output_fetch_done || bus.output_fetch_error) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: done=%b error=%b, required no completion",
                             bus.output_fetch_done, bus.output_fetch_error);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_done_error", {bus.output_fetch_done, bus.output_fetch_error},
                          (e.kind == K_DONE) ? 32'h2 : 32'h1);
                    if (e.kind == K_DONE) begin
                        check("sb_IR", bus.output_fetch_IR, e.ir);
                        check("sb_newPC", bus.output_fetch_newPC, e.newpc);
                        check("sb_PCWrite", bus.output_fetch_PCWrite, 1);
                    end else begin
                        check("sb_err_PCWrite", bus.output_fetch_PCWrite, 0);
                    end
                end
            end
        end
    end

    typedef struct {
        logic [15:0] pc;
        logic [15:0] data;
        int          waits;
        int          abort_cyc;
        kind_t       kind;
        logic [15:0] exp_newpc;
        int          exp_cycles;
    } vec_t;
    vec_t        vecs[7];
    logic [15:0] ir_model = '0;

    task automatic run_vec(input vec_t v, input int idx);
        int   cyc;
        int   pcw0;
        logic addr_bad;
        pc_load_val = v.pc;
        pc_load     = 1'b1;
        @(posedge CLK); #1;
        pc_load = 1'b0;
        bus.input_fetch_start = 1'b1;
        @(posedge CLK); #1;
        bus.input_fetch_start = 1'b0;
        pcw0     = pcw_count;
        cyc      = 0;
        addr_bad = 1'b0;
        while (bus.output_fetch_memReq && cyc < 40) begin
            bus.input_fetch_memReady = (cyc == v.waits);
            bus.input_fetch_memData  = (cyc == v.waits) ? v.data : ~v.data;
            bus.input_fetch_abort    = (cyc == v.abort_cyc);
            bus.input_fetch_start    = (cyc % 2 == 1);
            if (v.kind == K_DONE && cyc == v.waits)
                sb_q.push_back('{K_DONE, v.data, v.exp_newpc});
            if (v.kind == K_TMO && cyc == TIMEOUT - 1)
                sb_q.push_back('{K_TMO, 16'h0000, 16'h0000});
            @(negedge CLK);
            if (bus.output_fetch_memAddr !== v.pc || bus.output_fetch_busy !== 1'b1)
                addr_bad = 1'b1;
            @(posedge CLK); #1;
            bus.input_fetch_memReady = 1'b0;
            bus.input_fetch_abort    = 1'b0;
            bus.input_fetch_start    = 1'b0;
            cyc++;
        end
        check($sformatf("v%0d_req_cycles", idx), cyc, v.exp_cycles);
        check($sformatf("v%0d_memAddr_stable", idx), addr_bad, 0);
        if (v.kind != K_ABORT) begin
            @(posedge CLK); #1;
        end
        if (v.kind == K_DONE) ir_model = v.data;
        @(negedge CLK);
        check($sformatf("v%0d_busy_idle", idx), bus.output_fetch_busy, 0);
        check($sformatf("v%0d_pc", idx), pc_reg, v.exp_newpc);
        check($sformatf("v%0d_IR", idx), bus.output_fetch_IR, ir_model);
        check($sformatf("v%0d_pcwrites", idx), pcw_count - pcw0, (v.kind == K_DONE) ? 1 : 0);
        @(posedge CLK); #1;
    endtask

    initial begin
        bus.input_fetch_start    = 1'b0;
        bus.input_fetch_abort    = 1'b0;
        bus.input_fetch_memReady = 1'b0;
        bus.input_fetch_memData  = '0;

        vecs[0] = '{16'h0010, 16'hA5C3,  0, -1, K_DONE,  16'h0012,  1};
        vecs[1] = '{16'h0100, 16'h1234,  3, -1, K_DONE,  16'h0102,  4};
        vecs[2] = '{16'h0200, 16'hBEEF,  2,  2, K_ABORT, 16'h0200,  3};
        vecs[3] = '{16'h0300, 16'hCAFE,  5,  1, K_ABORT, 16'h0300,  2};
        vecs[4] = '{16'h0400, 16'h0F0F, 99, -1, K_TMO,   16'h0400, 16};
        vecs[5] = '{16'hFFFE, 16'h5A5A,  1, -1, K_DONE,  16'h0000,  2};
        vecs[6] = '{16'h1000, 16'h0001, 15, -1, K_DONE,  16'h1002, 16};

        // Reset held for two edges, then the INIT cycle, then IDLE.
        @(posedge CLK); #1;
        @(negedge CLK);
        check("rst_PCWrite", bus.output_fetch_PCWrite, 1);
        check("rst_newPC", bus.output_fetch_newPC, RESET_PC);
        check("rst_memReq", bus.output_fetch_memReq, 0);
        check("rst_IR", bus.output_fetch_IR, 0);
        @(posedge CLK); #1;
        Reset_n = 1'b1;
        @(negedge CLK);
        check("init_PCWrite", bus.output_fetch_PCWrite, 1);
        check("init_newPC", bus.output_fetch_newPC, RESET_PC);
        check("init_busy", bus.output_fetch_busy, 1);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("idle_busy", bus.output_fetch_busy, 0);
        check("idle_memReq", bus.output_fetch_memReq, 0);
        check("idle_PCWrite", bus.output_fetch_PCWrite, 0);
        check("idle_pc_seeded", pc_reg, RESET_PC);
        @(posedge CLK); #1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // memReady outside REQ must not touch IR.
        bus.input_fetch_memReady = 1'b1;
        bus.input_fetch_memData  = 16'hDEAD;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        bus.input_fetch_memReady = 1'b0;
        @(negedge CLK);
        check("idle_ready_IR", bus.output_fetch_IR, ir_model);
        check("idle_ready_busy", bus.output_fetch_busy, 0);
        @(posedge CLK); #1;

        // Reset asserted while a request is outstanding.
        pc_load_val = 16'h2000;
        pc_load     = 1'b1;
        @(posedge CLK); #1;
        pc_load = 1'b0;
        bus.input_fetch_start = 1'b1;
        @(posedge CLK); #1;
        bus.input_fetch_start = 1'b0;
        check("midrst_req_before", bus.output_fetch_memReq, 1);
        Reset_n = 1'b0;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("midrst_memReq", bus.output_fetch_memReq, 0);
        check("midrst_IR", bus.output_fetch_IR, 0);
        check("midrst_PCWrite", bus.output_fetch_PCWrite, 1);
        check("midrst_newPC", bus.output_fetch_newPC, RESET_PC);
        @(posedge CLK); #1;
        Reset_n = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("midrst_idle_busy", bus.output_fetch_busy, 0);
        check("midrst_pc", pc_reg, RESET_PC);
        ir_model = '0;

        run_vec(vecs[0], 7);

        check("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required completion of all sequences");
        $fatal(1, "simulation time limit");
    end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch sequencer that sits directly downstream of the program counter register and also drives its write port.
- On a start request from the main control FSM it:
  - captures the current PC;
  - issues a memory read with a request/ready handshake;
  - latches the returned word into the instruction register;
  - writes PC + PC_STEP back into the PC.
- It also seeds the PC with RESET_PC during reset and handles abort and memory timeout.

Parameters:
- ADDR_W, 16, width of PC and memory address.
- DATA_W, 16, width of instruction word and IR.
- PC_STEP, 2, increment added to the fetch address, modulo 2^ADDR_W.
- RESET_PC, 16'h0000, value written into the PC during and immediately after reset.
- TIMEOUT, 16, maximum REQ cycles before the error exit. 0 disables the timeout.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset_n  input  1  synchronous active-low reset.
- input_fetch_start  input  1  fetch request from the control FSM; sampled only in IDLE.
- input_fetch_abort  input  1  cancels an in-flight fetch.
- input_fetch_PC  input  ADDR_W  current PC register value.
- input_fetch_memReady  input  1  memory read data valid.
- input_fetch_memData  input  DATA_W  memory read data.
- output_fetch_memReq  output  1  memory read request.
- output_fetch_memAddr  output  ADDR_W  memory read address.
- output_fetch_IR  output  DATA_W  instruction register.
- output_fetch_PCWrite  output  1  PC write enable.
- output_fetch_newPC  output  ADDR_W  PC write value.
- output_fetch_done  output  1  one-cycle fetch-complete pulse.
- output_fetch_error  output  1  one-cycle timeout pulse.
- output_fetch_busy  output  1  high in every state except IDLE.

Behaviour:
- Clocking and reset:
  - Single clock domain. All state, counter, IR and address registers update on posedge CLK.
  - When Reset_n=0 at an edge:
    - state <= INIT;
    - IR <= 0;
    - latched address <= 0;
    - wait counter <= 0.
  - All outputs are decoded from the registered state and registers (Moore style).
- Output values per state (any output not listed is 0):
  - INIT: PCWrite=1, newPC=RESET_PC, memReq=0, memAddr=0, done=0, error=0, busy=1. Because INIT is the reset state, the PC receives RESET_PC during reset.
  - IDLE: memReq=0, PCWrite=0, busy=0.
  - REQ: memReq=1, memAddr=latched address, busy=1.
  - DONE: PCWrite=1, newPC=latched address + PC_STEP (truncated to ADDR_W), done=1, busy=1.
  - ERR: error=1, busy=1, PCWrite=0.
- State transitions (evaluated with Reset_n=1):
  - INIT -> IDLE unconditionally.
  - IDLE:
    - start=1 -> REQ; latch input_fetch_PC; clear the wait counter.
    - Otherwise stay in IDLE.
  - REQ, in this priority order:
    - abort=1 -> IDLE. No IR or PC update. Abort wins over memReady in the same cycle.
    - memReady=1 -> DONE; IR <= memData.
    - TIMEOUT != 0 and wait counter == TIMEOUT-1 -> ERR.
    - Otherwise wait counter += 1 and stay in REQ.
  - DONE -> IDLE.
  - ERR -> IDLE. IR and PC are unchanged.
- Timing:
  - Minimum fetch is 3 cycles: start sampled in IDLE, REQ with memReady=1, DONE.
  - The PC holds the new value in the cycle after DONE.
  - Each extra memory wait cycle adds 1.
  - Maximum REQ residency is TIMEOUT cycles.
- Boundary conditions:
  - start is ignored outside IDLE.
  - abort is ignored outside REQ.
  - memReady is ignored outside REQ.
  - Address wrap: latched 16'hFFFE with PC_STEP=2 gives newPC=16'h0000.
  - The memory must hold memData valid in the cycle memReady=1. memAddr is stable for the whole REQ residency.
  - Reset asserted mid-fetch forces INIT at the next edge: request dropped, IR cleared, PC reseeded.
  - The wait counter is wide enough to hold TIMEOUT-1 without overflow.

Test Plan:
1. Reset: hold Reset_n=0 for 2 cycles, then release. Required: PCWrite=1 and newPC=0 during reset and in the INIT cycle; busy=0 and memReq=0 on the following cycle.
2. Zero-wait fetch: PC=16'h0010, pulse start, memReady=1 with memData=16'hA5C3 in the first REQ cycle. Required: memAddr=0010; DONE one cycle later with IR=A5C3, PCWrite=1, newPC=0012, done=1; IDLE the next cycle.
3. Wait states: memReady delayed 3 cycles. Required: memReq=1 and memAddr stable for 4 REQ cycles; start pulses during REQ have no effect; done arrives exactly one cycle after memReady.
4. Abort collision: abort=1 and memReady=1 in the same REQ cycle. Required: return to IDLE; IR keeps its prior value; PCWrite never asserted; done=0.
5. Timeout: TIMEOUT=16, memReady held at 0. Required: exactly 16 REQ cycles, one error pulse, then IDLE; PC and IR unchanged.
6. Wrap and mid-fetch reset: fetch from PC=FFFE returns newPC=0000. Asserting Reset_n=0 during REQ gives memReq=0, IR=0 and PCWrite=1 with newPC=RESET_PC at the next edge.
